mem_port_arbiter: RTL

Arbiter and sequencer for one shared single-ported memory, used by the instruction-fetch stage and the data-memory stage of the 5-stage pipeline. Both requesters use a req/gnt/rvalid handshake. The block grants the port to one requester at a time and tracks the in-flight read through the fixed memory latency. It raises per-stage stall signals that drive the pipeline's PC/IF-ID write enables and the EX/MEM freeze. Data accesses have priority; a starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter for one shared single-ported memory between instruction fetch and data stages.
// Data has priority, a starvation counter bounds fetch wait, and reads are tracked through LAT.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_stall,
    output logic              d_stall
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] LAT_C    = 3'(LAT);
    localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);
    localparam logic       OWN_IF   = 1'b0;
    localparam logic       OWN_D    = 1'b1;

    state_t      state_r, state_s;
    logic        owner_r, owner_s;
    logic [2:0]  lat_cnt_r, lat_cnt_s;
    logic [3:0]  starve_cnt_r, starve_cnt_s;

    logic        rv_cycle_s;
    logic        decide_s;
    logic        if_win_s;
    logic        if_gnt_s;
    logic        d_gnt_s;
    logic        new_read_s;
    logic        if_rvalid_s;
    logic        d_rvalid_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    // Arbitration, memory strobe muxing and rvalid steering.
    always_comb begin
        rv_cycle_s  = (state_r == BUSY) && (lat_cnt_r == LAT_C);
        // Grants are suppressed while reset is held so outputs read as zero immediately.
        decide_s    = ~reset && ((state_r == IDLE) || rv_cycle_s);
        if_win_s    = if_req && (~d_req || (starve_cnt_r == STARVE_C));
        if_gnt_s    = decide_s && if_win_s;
        d_gnt_s     = decide_s && d_req && ~if_win_s;
        new_read_s  = if_gnt_s || (d_gnt_s && ~d_we);
        if_rvalid_s = rv_cycle_s && (owner_r == OWN_IF);
        d_rvalid_s  = rv_cycle_s && (owner_r == OWN_D);
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        if (d_gnt_s) begin
            mem_addr_s  = d_addr;
            mem_wdata_s = d_wdata;
        end else if (if_gnt_s) begin
            mem_addr_s  = if_addr;
            mem_wdata_s = '0;
        end else begin
            mem_addr_s  = '0;
            mem_wdata_s = '0;
        end
    end

    assign if_gnt    = if_gnt_s;
    assign d_gnt     = d_gnt_s;
    assign mem_en    = if_gnt_s | d_gnt_s;
    assign mem_we    = d_gnt_s & d_we;
    assign mem_addr  = mem_addr_s;
    assign mem_wdata = mem_wdata_s;
    assign if_rvalid = if_rvalid_s;
    assign d_rvalid  = d_rvalid_s;
    assign if_rdata  = if_rvalid_s ? mem_rdata : '0;
    assign d_rdata   = d_rvalid_s ? mem_rdata : '0;
    assign if_stall  = if_req & ~if_rvalid_s;
    assign d_stall   = d_req & ~(d_gnt_s & d_we) & ~d_rvalid_s;

    // Next-state, latency counter, owner and starvation counter.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        lat_cnt_s    = lat_cnt_r;
        starve_cnt_s = starve_cnt_r;
        case (state_r)
            IDLE: begin
                state_s   = IDLE;
                lat_cnt_s = 3'd0;
            end
            BUSY: begin
                if (rv_cycle_s) begin
                    state_s   = IDLE;
                    lat_cnt_s = 3'd0;
                end else begin
                    state_s   = BUSY;
                    lat_cnt_s = lat_cnt_r + 3'd1;
                end
            end
            default: begin
                state_s   = IDLE;
                lat_cnt_s = 3'd0;
            end
        endcase
        if (new_read_s) begin
            state_s   = BUSY;
            lat_cnt_s = 3'd1;
            owner_s   = d_gnt_s ? OWN_D : OWN_IF;
        end else begin
            owner_s   = owner_r;
        end
        if (if_gnt_s) begin
            starve_cnt_s = 4'd0;
        end else if (decide_s && if_req && d_gnt_s) begin
            starve_cnt_s = (starve_cnt_r == STARVE_C) ? starve_cnt_r : starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_s = starve_cnt_r;
        end
    end

    // State registers; reset drops any in-flight read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            owner_r      <= OWN_IF;
            lat_cnt_r    <= 3'd0;
            starve_cnt_r <= 4'd0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            lat_cnt_r    <= lat_cnt_s;
            starve_cnt_r <= starve_cnt_s;
        end
    end

endmodule
